// File: rtl/led_pwm_fader.sv
// led_pwm_fader: breathing-LED PWM fader that ramps duty up, holds, ramps down, holds, and repeats.
// Ports:
//   clk          - single clock, all state on its rising edge
//   rst          - asynchronous active-high reset
//   currentCount - free-running count from the upstream counter (PWM compare + tick source)
//   ena          - run enable; low freezes the fade and silences the LED
//   pwm_out      - registered PWM drive for the LED
//   duty         - current duty register
//   phase        - fade state: 0=RISE, 1=HOLD_HI, 2=FALL, 3=HOLD_LO
//   cycle_done   - one-clock pulse when a full fade cycle completes
// Build option: define LED_FADER_GAMMA_EN to drive the PWM compare with (duty*duty)>>8.
module led_pwm_fader #(
    parameter int STEP       = 1,
    parameter int HOLD_TICKS = 16,
    parameter int TICK_BIT   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] currentCount,
    input  logic        ena,
    output logic        pwm_out,
    output logic [7:0]  duty,
    output logic [1:0]  phase,
    output logic        cycle_done
);
    typedef enum logic [1:0] {RISE = 2'd0, HOLD_HI = 2'd1, FALL = 2'd2, HOLD_LO = 2'd3} phase_e;
    localparam logic [8:0] STEP9    = 9'(STEP);
    // HOLD_TICKS==0 collapses to "leave on the first tick", same as a limit of 0
    localparam logic [7:0] HOLD_MAX = 8'((HOLD_TICKS == 0) ? 0 : HOLD_TICKS - 1);
    phase_e     state_q, state_d;
    logic [7:0] duty_q, duty_d, hold_q, hold_d, eff_duty;
    logic       prev_q, pwm_q, done_q, done_d, tick, hold_end;
    logic [8:0] sum;
    // only the tick bit and the low byte matter; the rest is deliberately ignored
    logic       unused_cc;
    assign unused_cc = ^currentCount;
    assign tick      = currentCount[TICK_BIT] & ~prev_q & ena;
    assign sum       = {1'b0, duty_q} + STEP9;
    assign hold_end  = hold_q >= HOLD_MAX;
`ifdef LED_FADER_GAMMA_EN
    logic [15:0] sq;
    assign sq       = {8'd0, duty_q} * {8'd0, duty_q};
    assign eff_duty = sq[15:8];
`else
    assign eff_duty = duty_q;
`endif
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        if (tick) begin
            case (state_q)
                RISE: begin
                    duty_d = (sum >= 9'd255) ? 8'hFF : sum[7:0];
                    hold_d = (sum >= 9'd255) ? 8'd0 : hold_q;
                    state_d = (sum >= 9'd255) ? HOLD_HI : RISE;
                end
                HOLD_HI: begin
                    hold_d  = hold_end ? 8'd0 : hold_q + 8'd1;
                    state_d = hold_end ? FALL : HOLD_HI;
                end
                FALL: begin
                    duty_d  = ({1'b0, duty_q} <= STEP9) ? 8'd0 : duty_q - STEP9[7:0];
                    hold_d  = ({1'b0, duty_q} <= STEP9) ? 8'd0 : hold_q;
                    state_d = ({1'b0, duty_q} <= STEP9) ? HOLD_LO : FALL;
                end
                HOLD_LO: begin
                    hold_d  = hold_end ? 8'd0 : hold_q + 8'd1;
                    state_d = hold_end ? RISE : HOLD_LO;
                    done_d  = hold_end;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RISE;
            duty_q  <= 8'd0;
            hold_q  <= 8'd0;
            prev_q  <= 1'b0;
            pwm_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            hold_q  <= hold_d;
            prev_q  <= currentCount[TICK_BIT];
            pwm_q   <= ena & (currentCount[7:0] < eff_duty);
            done_q  <= done_d;
        end
    end
    assign pwm_out    = pwm_q;
    assign duty       = duty_q;
    assign phase      = state_q;
    assign cycle_done = done_q;
endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: directed self-checking bench for led_pwm_fader (STEP=32, HOLD_TICKS=4, TICK_BIT=7).
module tb_led_pwm_fader;
    logic        clk = 1'b0;
    logic        rst, ena, pwm_out, cycle_done;
    logic [15:0] cc;
    logic [7:0]  duty, pv;
    logic [1:0]  phase;
    int          checks, errors, cd_seen, cd_before, n;
`ifdef LED_FADER_GAMMA_EN
    localparam int EFF = 16;
`else
    localparam int EFF = 64;
`endif
    int exp_duty [24] = '{32, 64, 96, 128, 160, 192, 224, 255, 255, 255, 255, 255,
                          223, 191, 159, 127, 95, 63, 31, 0, 0, 0, 0, 0};
    int exp_phase[24] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2,
                          2, 2, 2, 2, 2, 2, 2, 3, 3, 3, 3, 0};

    led_pwm_fader #(.STEP(32), .HOLD_TICKS(4), .TICK_BIT(7)) dut (
        .clk(clk), .rst(rst), .currentCount(cc), .ena(ena),
        .pwm_out(pwm_out), .duty(duty), .phase(phase), .cycle_done(cycle_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (cycle_done === 1'b1) cd_seen++;
        cc = cc + 16'd1;
    endtask

    task automatic run_to_tick();
        int k = 0;
        do begin
            step();
            k++;
        end while (cc[7:0] != 8'h81 && k < 600);
    endtask

    initial begin
        checks = 0; errors = 0; cd_seen = 0;
        rst = 1'b1; ena = 1'b1; cc = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_duty", duty, 0);
        chk("rst_phase", phase, 0);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_cdone", cycle_done, 0);
        rst = 1'b0;
        while (cc != 16'h0080) step();
        chk("pre_tick_duty", duty, 0);
        chk("pre_tick_pwm", pwm_out, 0);
        step();
        chk("t1_duty", duty, 32);
        chk("t1_phase", phase, 0);
        for (int t = 2; t <= 24; t++) begin
            run_to_tick();
            chk($sformatf("t%0d_duty", t), duty, exp_duty[t-1]);
            chk($sformatf("t%0d_phase", t), phase, exp_phase[t-1]);
            chk($sformatf("t%0d_cdone", t), cycle_done, t == 24);
        end
        step();
        chk("cdone_width", cycle_done, 0);
        chk("cdone_count", cd_seen, 1);
        run_to_tick();
        run_to_tick();
        chk("pwm_duty", duty, 64);
        for (int i = 0; i < 256; i++) begin
            step();
            pv = cc[7:0] - 8'd1;
            chk($sformatf("pwm_at_%0d", pv), pwm_out, pv < EFF);
        end
        chk("pre_hold_duty", duty, 96);
        ena = 1'b0;
        cd_before = cd_seen;
        for (int i = 0; i < 1000; i++) begin
            step();
            chk("hold_pwm", pwm_out, 0);
            chk("hold_duty", duty, 96);
        end
        chk("hold_phase", phase, 0);
        chk("hold_cdone", cd_seen, cd_before);
        ena = 1'b1;
        run_to_tick();
        chk("resume_duty", duty, 128);
        n = 0;
        while (!(duty == 8'd159 && phase == 2'd2) && n < 20) begin
            run_to_tick();
            n++;
        end
        chk("fall_159_duty", duty, 159);
        chk("fall_159_phase", phase, 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_duty", duty, 0);
        chk("arst_phase", phase, 0);
        chk("arst_pwm", pwm_out, 0);
        chk("arst_cdone", cycle_done, 0);
        cc = 16'd0;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("post_arst_duty", duty, 0);
        run_to_tick();
        chk("restart_duty", duty, 32);
        chk("restart_phase", phase, 0);
        cc = 16'hFFF0;
        repeat (40) step();
        chk("wrap_duty", duty, 32);
        chk("wrap_phase", phase, 0);
        run_to_tick();
        chk("after_wrap_duty", duty, 64);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
